duty_ramp_ctrl: RTL
===================

DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4: clk cycles per ramp step; legal range 1..65535.
REQ-002 Parameter STEP, default 5: maximum duty change per ramp step; legal range 1..255.
REQ-003 Parameter MAX_DUTY, default 100: upper clamp for duty, in percent.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 target  in  8  requested duty in percent; sampled only on handshake.
REQ-007 target_valid  in  1  target is valid this cycle.
REQ-008 target_ready  out  1  block accepts a target this cycle.
REQ-009 hold  in  1  freezes ramp progress while high.
REQ-010 duty_cycle  out  8  registered duty for the downstream PWM stage.
REQ-011 busy  out  1  ramp in progress.
REQ-012 done  out  1  one-cycle pulse when duty_cycle reaches the latched target.

Function
REQ-013 The handshake shall fire when target_valid and target_ready are both 1 on the same rising edge.
REQ-014 target_ready shall be 1 only in IDLE; target_valid while not ready shall be ignored, with no queueing.
REQ-015 On handshake, the block shall latch the target, clamped to MAX_DUTY when target > MAX_DUTY.
REQ-016 The FSM shall have three states: IDLE, RAMP and DONE.
REQ-017 IDLE to RAMP on handshake when the clamped target differs from duty_cycle; IDLE to DONE on handshake when they are equal.
REQ-018 On entry to RAMP, the prescaler shall be cleared to 0.
REQ-019 In RAMP with hold=0, the prescaler shall increment each cycle; when it reaches TICK_DIV-1 it shall wrap to 0 and one step shall occur.
REQ-020 On a step, duty_cycle shall move toward the target by min(STEP, |target - duty_cycle|), with no overshoot.
REQ-021 Difference arithmetic shall use 9-bit signed width; duty_cycle shall never exceed MAX_DUTY or go below 0.
REQ-022 RAMP to DONE on the step that makes duty_cycle equal the target.
REQ-023 DONE shall last exactly one cycle, assert done=1, and then go to IDLE.
REQ-024 busy shall be 1 in RAMP and DONE, and 0 in IDLE.
REQ-025 With hold=1, the prescaler and duty_cycle shall be frozen and the state unchanged; hold in IDLE shall have no effect.
REQ-026 Step latency: after a handshake with TICK_DIV=N and hold=0, the first duty_cycle change shall be visible N cycles after the accept edge.
REQ-027 Total ramp time: for a distance D, ramp time shall be ceil(D/STEP)*N cycles, plus 1 cycle of DONE.
REQ-028 duty_cycle shall be updated only on step edges.

Reset
REQ-029 While reset=1: state=IDLE, duty_cycle=0, prescaler=0, latched target=0, busy=0, done=0, target_ready=0.
REQ-030 target_ready shall go to 1 on the first clock edge after reset deasserts.
REQ-031 Reset asserted mid-ramp shall abort immediately; no done pulse shall be issued.

Structure
REQ-032 The FSM state encoding and the default MAX_DUTY shall be placed in the shared package arm_pwm_pkg.
REQ-033 The prescaler shall be a sub-module, tick_prescaler (parameter TICK_DIV; inputs clr and en; output tick).
REQ-034 Implementation size shall be about 150-250 lines in total.

Verification
REQ-035 Defaults, target=50 accepted from duty 0: duty_cycle steps 5,10,...,50 every 4 cycles; done pulses once, 41 cycles after accept; busy drops with done.
REQ-036 target=200: clamps to 100; duty_cycle ends at 100, never above.
REQ-037 From duty 50, target=48: one step lands on 48 with no overshoot below 48; done follows.
REQ-038 hold=1 for 10 cycles mid-ramp at duty 20: duty_cycle and prescaler are frozen; the ramp resumes and the total time extends by exactly 10 cycles.
REQ-039 target=current duty (e.g. 0 after reset): DONE next cycle, done=1 for 1 cycle, no duty change; target_valid during RAMP is ignored.
REQ-040 reset pulse at duty 30 while ramping to 80: duty_cycle=0 and IDLE immediately; target_ready=1 one edge after release; no done.

Source files
------------

// File: rtl/arm_pwm_pkg.sv
// Shared PWM types: ramp FSM encoding, default duty clamp and the bounded duty step.
// Combinational helpers only; no latency, no backpressure.
package arm_pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_MAX_DUTY = 100;

    // Moves duty toward tgt by at most step; the signed 9-bit difference
    // keeps a downward ramp from wrapping and the min() prevents overshoot.
    function automatic logic [7:0] step_toward(
        input logic [7:0] duty,
        input logic [7:0] tgt,
        input logic [7:0] step
    );
        logic signed [8:0] diff;
        logic        [8:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, duty});
        mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
        if (mag > {1'b0, step}) begin
            mag = {1'b0, step};
        end
        return diff[8] ? (duty - mag[7:0]) : (duty + mag[7:0]);
    endfunction

endpackage

// File: rtl/duty_ramp_ctrl_if.sv
// Target request channel into the duty ramp controller (valid/ready).
// Pure wiring; backpressure is target_ready driven by the slave.
interface duty_ramp_ctrl_if;
    logic [7:0] target;
    logic       target_valid;
    logic       target_ready;

    modport master (output target, output target_valid, input  target_ready);
    modport slave  (input  target, input  target_valid, output target_ready);
endinterface

// File: rtl/tick_prescaler.sv
// Step prescaler: tick pulses on the cycle the counter sits at TICK_DIV-1 while enabled.
// Latency: first tick TICK_DIV enabled cycles after clr; en low freezes the count.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Duty ramp controller: moves duty_cycle toward a latched target by up to STEP every TICK_DIV cycles.
// Latency: first step TICK_DIV cycles after accept; backpressure: target_ready only while idle, no queueing.
module duty_ramp_ctrl
    import arm_pwm_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int STEP     = 5,
    parameter int MAX_DUTY = DEFAULT_MAX_DUTY
) (
    input  logic                   clk,
    input  logic                   reset,
    duty_ramp_ctrl_if.slave        tgt,
    input  logic                   hold,
    output logic [7:0]             duty_cycle,
    output logic                   busy,
    output logic                   done
);

    localparam logic [7:0] MAX8  = 8'(MAX_DUTY);
    localparam logic [7:0] STEP8 = 8'(STEP);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tgt_q;
    logic [7:0] tgt_clamped;
    logic [7:0] duty_nxt;
    logic       rdy_en;
    logic       accept;
    logic       tick;
    logic       pre_clr;
    logic       pre_en;

    // rdy_en holds ready low through reset and for the release edge itself.
    assign tgt.target_ready = rdy_en && (state == ST_IDLE);
    assign accept           = tgt.target_valid && tgt.target_ready;
    assign tgt_clamped      = (tgt.target > MAX8) ? MAX8 : tgt.target;
    assign duty_nxt         = step_toward(duty_cycle, tgt_q, STEP8);

    assign pre_clr = (state != ST_RAMP);
    assign pre_en  = (state == ST_RAMP) && !hold;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (tgt_clamped == duty_cycle) ? ST_DONE : ST_RAMP;
                end
            end
            ST_RAMP: begin
                busy = 1'b1;
                if (tick && (duty_nxt == tgt_q)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            duty_cycle <= '0;
            tgt_q      <= '0;
            rdy_en     <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (accept) begin
                tgt_q <= tgt_clamped;
            end
            if (tick) begin
                duty_cycle <= duty_nxt;
            end
        end
    end

endmodule
